// File: rtl/as_imem_scan_loader.sv
// -----------------------------------------------------------------------------
// as_imem_scan_loader
//
// Purpose: JTAG data-register front end that loads (and optionally reads back)
// instruction memory. A scan register SR = {addr, data, inc, rd, we} is
// shifted through tdi/tdo. An update issues one memory access through a
// small IDLE/REQ/WAIT/DONE handshake. A capture returns
// {last_addr, last_rdata, 1'b0, busy, err}.
//
// Ports:
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   sel_i                       loader data register selected in the TAP
//   capture_dr_i, shift_dr_i,
//   update_dr_i                 one-cycle TAP state strobes
//   tdi_i / tdo_o               serial in / registered serial out
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o     memory request (held stable until ack)
//   mem_ack_i, mem_rdata_i      memory response
//   busy_o, err_o               status (err is sticky, cleared on capture)
//
// Configuration: define IMEM_SCAN_READBACK_EN to build the read path
// (rd decode, last_rdata register, mem_rdata_i capture). Without it a
// read command is a NOP that flags err and the captured data field is zero.
// -----------------------------------------------------------------------------
module as_imem_scan_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sel_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int         L       = ADDR_W + DATA_W + 3;
  localparam logic [7:0] TIMEOUT = 8'd255;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [L-1:0]      sr_q, sr_d;
  logic              tdo_q, tdo_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              shf, cap, upd;
  logic              sr_we, sr_rd, sr_inc;
  logic [DATA_W-1:0] sr_data;
  logic [ADDR_W-1:0] sr_addr;
  logic [ADDR_W-1:0] target;
  logic              cmd_read, cmd_go, cmd_bad, err_set;
  logic [DATA_W-1:0] cap_data;

  assign shf = sel_i & shift_dr_i;
  assign cap = sel_i & capture_dr_i;
  assign upd = sel_i & update_dr_i;

  assign sr_we   = sr_q[0];
  assign sr_rd   = sr_q[1];
  assign sr_inc  = sr_q[2];
  assign sr_data = sr_q[DATA_W+2:3];
  assign sr_addr = sr_q[L-1:DATA_W+3];

  // Auto-increment wraps naturally at 2^ADDR_W.
  assign target = sr_inc ? (last_addr_q + ADDR_W'(STEP)) : sr_addr;

`ifdef IMEM_SCAN_READBACK_EN
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] last_rdata_q, last_rdata_d;

  assign cmd_read = sr_rd & ~sr_we;
  assign cmd_bad  = sr_rd & sr_we;
  assign cap_data = last_rdata_q;
`else
  logic unused_rdata;

  // Without the read path any rd bit is an error (rd-only becomes a NOP).
  assign cmd_read     = 1'b0;
  assign cmd_bad      = sr_rd;
  assign cap_data     = '0;
  assign unused_rdata = ^mem_rdata_i;
`endif

  assign cmd_go = sr_we | cmd_read;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    tdo_d       = tdo_q;
    last_addr_d = last_addr_q;
    err_d       = err_q;
    req_d       = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_set     = 1'b0;
`ifdef IMEM_SCAN_READBACK_EN
    rd_d         = rd_q;
    last_rdata_d = last_rdata_q;
`endif

    if (shf) begin
      sr_d  = {tdi_i, sr_q[L-1:1]};
      tdo_d = sr_q[0];
    end else if (cap) begin
      sr_d = {last_addr_q, cap_data, 1'b0, busy_q, err_q};
      // Clear-on-read: the err bit just captured is the one being cleared.
      if (err_q) err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (upd) begin
          if (cmd_go) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = sr_we;
            addr_d  = target;
            wdata_d = sr_we ? sr_data : '0;
`ifdef IMEM_SCAN_READBACK_EN
            rd_d    = cmd_read;
`endif
          end
          if (cmd_bad) err_set = 1'b1;
        end
      end
      REQ: begin
        // Any ack seen while the request is being presented is ignored.
        state_d = WAIT;
        cnt_d   = 8'd1;
      end
      WAIT: begin
        if (mem_ack_i) begin
          state_d     = DONE;
          last_addr_d = addr_q;
`ifdef IMEM_SCAN_READBACK_EN
          if (rd_q) last_rdata_d = mem_rdata_i;
          rd_d = 1'b0;
`endif
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end else if (cnt_q == TIMEOUT) begin
          // Give up on the access; last_addr keeps its previous value.
          state_d = IDLE;
          err_set = 1'b1;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
`ifdef IMEM_SCAN_READBACK_EN
          rd_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Updates arriving while an access is in flight are dropped.
    if (upd && (state_q != IDLE)) err_set = 1'b1;
    // A new error wins over a simultaneous clear so no event is lost.
    if (err_set) err_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      tdo_q       <= 1'b0;
      last_addr_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
`ifdef IMEM_SCAN_READBACK_EN
      rd_q         <= 1'b0;
      last_rdata_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tdo_q       <= tdo_d;
      last_addr_q <= last_addr_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
`ifdef IMEM_SCAN_READBACK_EN
      rd_q         <= rd_d;
      last_rdata_q <= last_rdata_d;
`endif
    end
  end

  assign tdo_o       = tdo_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_as_imem_scan_loader.sv
// -----------------------------------------------------------------------------
// tb_as_imem_scan_loader
//
// Self-checking bench for as_imem_scan_loader (default parameters). Directed
// table of commands with expected results, hand-written multi-cycle corner
// sequences, then randomized commands checked against a behavioural model.
// Honors IMEM_SCAN_READBACK_EN to select the expected read behaviour.
// -----------------------------------------------------------------------------
module tb_as_imem_scan_loader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int STEP   = 4;
  localparam int L      = ADDR_W + DATA_W + 3;
`ifdef IMEM_SCAN_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk, rstn, sel, cap_s, shf_s, upd_s, tdi, tdo;
  logic              mem_req, mem_we, mem_ack, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  as_imem_scan_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP(STEP)) dut (
    .clk_i(clk), .rstn_i(rstn), .sel_i(sel),
    .capture_dr_i(cap_s), .shift_dr_i(shf_s), .update_dr_i(upd_s),
    .tdi_i(tdi), .tdo_o(tdo),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [ADDR_W-1:0] m_last_addr;
  logic [DATA_W-1:0] m_last_rdata;
  bit                m_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                inc, rd, we;
    bit                exp_req;
    logic [ADDR_W-1:0] exp_addr;
    bit                exp_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    bit                cap_err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [L-1:0] din, output logic [L-1:0] dout);
    for (int i = 0; i < L; i++) begin
      sel = 1'b1; shf_s = 1'b1; tdi = din[i];
      tick();
      dout[i] = tdo;
    end
    shf_s = 1'b0; tdi = 1'b0;
  endtask

  task automatic pulse_update();
    sel = 1'b1; upd_s = 1'b1;
    tick();
    upd_s = 1'b0;
  endtask

  task automatic capture_read(output logic [L-1:0] v);
    sel = 1'b1; cap_s = 1'b1;
    tick();
    cap_s = 1'b0;
    scan('0, v);
  endtask

  function automatic logic [L-1:0] exp_cap(input bit busy_bit);
    logic [DATA_W-1:0] d;
    d = RB ? m_last_rdata : {DATA_W{1'b0}};
    return {m_last_addr, d, 1'b0, busy_bit, m_err};
  endfunction

  task automatic capture_check(input string name);
    logic [L-1:0] v;
    capture_read(v);
    check(name, 64'(v), 64'(exp_cap(1'b0)));
    m_err = 1'b0;
  endtask

  // Shift a command, update, and complete the handshake with an ack after
  // 'delay' extra WAIT cycles. Optionally drops a second update during WAIT.
  task automatic access(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit inc, input bit rd, input bit we,
                        input int delay, input logic [DATA_W-1:0] rdata, input bit drop,
                        output bit got_req, output logic [ADDR_W-1:0] got_addr,
                        output logic [DATA_W-1:0] got_wdata, output bit got_we);
    logic [L-1:0] junk;
    scan({a, d, inc, rd, we}, junk);
    pulse_update();
    got_req   = mem_req;
    got_addr  = mem_addr;
    got_wdata = mem_wdata;
    got_we    = mem_we;
    if (got_req) begin
      tick();
      check("req_one_cycle", 64'(mem_req), 64'd0);
      check("busy_in_wait", 64'(busy), 64'd1);
      if (drop) begin
        pulse_update();
        check("drop_no_req", 64'(mem_req), 64'd0);
      end
      for (int i = 0; i < delay; i++) tick();
      mem_ack = 1'b1; mem_rdata = rdata;
      tick();
      mem_ack = 1'b0; mem_rdata = DATA_W'($urandom);
      tick();
      check("busy_after_done", 64'(busy), 64'd0);
    end else begin
      tick();
      check("nop_no_req", 64'(mem_req), 64'd0);
      check("nop_not_busy", 64'(busy), 64'd0);
    end
  endtask

  // Reference model: derive the expected access from the command rules.
  task automatic model_cmd(input logic [ADDR_W-1:0] a, input bit inc, input bit rd,
                           input bit we, input bit drop, input logic [DATA_W-1:0] rdata,
                           output bit exp_req, output logic [ADDR_W-1:0] exp_addr,
                           output bit exp_we);
    bit is_read;
    exp_addr = inc ? ADDR_W'((int'(m_last_addr) + STEP) % (1 << ADDR_W)) : a;
    is_read  = RB && rd && !we;
    exp_req  = we || is_read;
    exp_we   = we;
    if (we && rd) m_err = 1'b1;
    if (!RB && rd && !we) m_err = 1'b1;
    if (exp_req) begin
      m_last_addr = exp_addr;
      if (is_read) m_last_rdata = rdata;
      if (drop) m_err = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0]      v, pat, junk;
    bit                greq, gwe, ereq, ewe;
    logic [ADDR_W-1:0] gaddr, eaddr, a;
    logic [DATA_W-1:0] gwd, d, rdv;
    bit                inc, rd, we, drop;
    int                dly, k;
    logic              t0;

    tbl[0] = '{10'h004, 32'h0130_0093, 1'b0, 1'b0, 1'b1, 1'b1, 10'h004, 1'b1, 10'h004, 32'h0, 1'b0};
    tbl[1] = '{10'h3FC, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1, 10'h3FC, 1'b1, 10'h3FC, 32'h0, 1'b0};
    tbl[2] = '{10'h155, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b1, 10'h000, 1'b1, 10'h000, 32'h0, 1'b0};
    tbl[3] = '{10'h0AA, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 1'b1, 10'h004, 1'b1, 10'h004, 32'h0, 1'b0};
    tbl[4] = '{10'h200, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h004, 32'h0, 1'b0};
    tbl[5] = '{10'h020, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 1'b1, 10'h020, 1'b1, 10'h020, 32'h0, 1'b1};
`ifdef IMEM_SCAN_READBACK_EN
    tbl[6] = '{10'h010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 1'b0, 10'h010, 32'hDEAD_BEEF, 1'b0};
    tbl[7] = '{10'h1FF, 32'h6666_6666, 1'b1, 1'b0, 1'b1, 1'b1, 10'h014, 1'b1, 10'h014, 32'hDEAD_BEEF, 1'b0};
`else
    tbl[6] = '{10'h010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h020, 32'h0, 1'b1};
    tbl[7] = '{10'h1FF, 32'h6666_6666, 1'b1, 1'b0, 1'b1, 1'b1, 10'h024, 1'b1, 10'h024, 32'h0, 1'b0};
`endif

    rstn = 1'b0; sel = 1'b0; cap_s = 1'b0; shf_s = 1'b0; upd_s = 1'b0; tdi = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_last_addr = '0; m_last_rdata = '0; m_err = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Reset state
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    capture_check("rst_capture");

    // Directed table
    for (int i = 0; i < 8; i++) begin
      access(tbl[i].addr, tbl[i].data, tbl[i].inc, tbl[i].rd, tbl[i].we, i % 3,
             32'hDEAD_BEEF, 1'b0, greq, gaddr, gwd, gwe);
      check($sformatf("tbl%0d_req", i), 64'(greq), 64'(tbl[i].exp_req));
      if (tbl[i].exp_req) begin
        check($sformatf("tbl%0d_addr", i), 64'(gaddr), 64'(tbl[i].exp_addr));
        check($sformatf("tbl%0d_we", i), 64'(gwe), 64'(tbl[i].exp_we));
        if (tbl[i].exp_we)
          check($sformatf("tbl%0d_wdata", i), 64'(gwd), 64'(tbl[i].data));
      end
      capture_read(v);
      check($sformatf("tbl%0d_cap", i), 64'(v),
            64'({tbl[i].cap_addr, tbl[i].cap_data, 1'b0, 1'b0, tbl[i].cap_err}));
    end
    m_last_addr  = tbl[7].cap_addr;
    m_last_rdata = tbl[7].cap_data;
    m_err        = 1'b0;

    // Strobes with sel low are ignored; tdo holds
    sel = 1'b1; cap_s = 1'b1; tick(); cap_s = 1'b0;
    sel = 1'b1; shf_s = 1'b1; tdi = 1'b1; tick(); shf_s = 1'b0;
    t0 = tdo;
    sel = 1'b0; shf_s = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    shf_s = 1'b0; upd_s = 1'b1; tick(); upd_s = 1'b0; cap_s = 1'b1; tick(); cap_s = 1'b0;
    check("nosel_tdo_hold", 64'(tdo), 64'(t0));
    check("nosel_no_req", 64'(mem_req), 64'd0);
    check("nosel_not_busy", 64'(busy), 64'd0);
    scan('0, v);
    pat = exp_cap(1'b0);
    check("nosel_sr_intact", 64'(v), 64'({1'b1, pat[L-1:1]}));

    // Ack presented during the request cycle is ignored
    scan({10'h080, 32'h0000_0077, 3'b001}, junk);
    pulse_update();
    check("early_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    tick();
    check("early_ack_busy", 64'(busy), 64'd1);
    check("early_ack_addr", 64'(mem_addr), 64'h080);
    check("early_ack_we", 64'(mem_we), 64'd1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    check("early_ack_done", 64'(busy), 64'd0);
    m_last_addr = 10'h080;
    capture_check("early_ack_cap");

    // Update while busy is dropped; shifting while busy still works
    scan({10'h0C0, 32'hA5A5_A5A5, 3'b001}, junk);
    pulse_update();
    check("busy_drop_req1", 64'(mem_req), 64'd1);
    tick();
    pat = {10'h2B3, 32'h0F0F_1234, 3'b011};
    scan(pat, junk);
    pulse_update();
    check("busy_drop_noreq", 64'(mem_req), 64'd0);
    check("busy_drop_addr", 64'(mem_addr), 64'h0C0);
    tick();
    check("busy_drop_noreq2", 64'(mem_req), 64'd0);
    check("busy_drop_busy", 64'(busy), 64'd1);
    scan('0, v);
    check("busy_shift_sr", 64'(v), 64'(pat));
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    check("busy_drop_idle", 64'(busy), 64'd0);
    m_last_addr = 10'h0C0; m_err = 1'b1;
    capture_check("busy_drop_err1");
    capture_check("busy_drop_err0");

    // Timeout: no ack ever arrives
    scan({10'h2A0, 32'hCAFE_F00D, 3'b001}, junk);
    pulse_update();
    check("to_req", 64'(mem_req), 64'd1);
    k = 0;
    tick(); k++;
    sel = 1'b1; cap_s = 1'b1; tick(); cap_s = 1'b0; k++;
    scan('0, v); k += L;
    check("to_cap_busy", 64'(v[1]), 64'd1);
    check("to_cap_err", 64'(v[0]), 64'd0);
    while (k < 250) begin tick(); k++; end
    check("to_busy_250", 64'(busy), 64'd1);
    while (k < 260) begin tick(); k++; end
    check("to_busy_260", 64'(busy), 64'd0);
    check("to_err", 64'(err), 64'd1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    check("to_late_ack", 64'(busy), 64'd0);
    m_err = 1'b1;
    capture_check("to_cap_after");

    // Reset while waiting for an ack
    scan({10'h100, 32'h1234_5678, 3'b001}, junk);
    pulse_update();
    tick();
    pulse_update();
    check("rw_err_pre", 64'(err), 64'd1);
    rstn = 1'b0;
    #2;
    check("rw_req", 64'(mem_req), 64'd0);
    check("rw_we", 64'(mem_we), 64'd0);
    check("rw_addr", 64'(mem_addr), 64'd0);
    check("rw_wdata", 64'(mem_wdata), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_err", 64'(err), 64'd0);
    check("rw_tdo", 64'(tdo), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A; tick(); mem_ack = 1'b0; tick();
    check("rw_late_busy", 64'(busy), 64'd0);
    check("rw_late_req", 64'(mem_req), 64'd0);
    check("rw_late_err", 64'(err), 64'd0);
    m_last_addr = '0; m_last_rdata = '0; m_err = 1'b0;
    capture_check("rw_cap");

    // Randomized commands against the model
    for (int it = 0; it < 30; it++) begin
      a    = ADDR_W'($urandom);
      d    = DATA_W'($urandom);
      inc  = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      dly  = int'($urandom_range(0, 4));
      rdv  = DATA_W'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      access(a, d, inc, rd, we, dly, rdv, drop, greq, gaddr, gwd, gwe);
      model_cmd(a, inc, rd, we, drop, rdv, ereq, eaddr, ewe);
      check($sformatf("rnd%0d_req", it), 64'(greq), 64'(ereq));
      if (ereq) begin
        check($sformatf("rnd%0d_addr", it), 64'(gaddr), 64'(eaddr));
        check($sformatf("rnd%0d_we", it), 64'(gwe), 64'(ewe));
        if (ewe) check($sformatf("rnd%0d_wdata", it), 64'(gwd), 64'(d));
      end
      capture_check($sformatf("rnd%0d_cap", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/as_imem_scan_loader.md
AS_IMEM_SCAN_LOADER -- requirements
Module: as_imem_scan_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the I-Mem byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter STEP, default 4, meaning the byte increment per auto-increment write.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have port sel_i, input, 1 bit: the loader data register is selected (IR = 8'h80).
REQ-007 SHALL have ports capture_dr_i, shift_dr_i and update_dr_i, input, 1 bit each: one-cycle TAP state strobes, mutually exclusive.
REQ-008 SHALL have port tdi_i, input, 1 bit: serial data in. Port tdo_o, output, 1 bit: serial data out.
REQ-009 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_W) and mem_wdata_o (output, DATA_W): the memory request.
REQ-010 SHALL have ports mem_ack_i (input, 1) and mem_rdata_i (input, DATA_W): the memory response.
REQ-011 SHALL have ports busy_o (output, 1) and err_o (output, 1): status.

Function
REQ-012 The scan register SR SHALL be L = ADDR_W+DATA_W+3 bits: {addr, data, inc, rd, we}, with we at the LSB.
REQ-013 On a shift_dr_i cycle with sel_i=1, SR SHALL shift right: tdi_i enters the MSB and tdo_o = SR[0] (registered).
REQ-014 On a capture_dr_i cycle with sel_i=1, SR SHALL load {last_addr, last_rdata, 1'b0, busy, err}.
REQ-015 On an update_dr_i cycle with sel_i=1 and FSM in IDLE, the command SHALL be latched and decoded.
- we=1: WRITE.
- rd=1 and we=0: READ.
- we=0 and rd=0: NOP; last_addr is unchanged.
- we=1 and rd=1: write only, and err is set.
REQ-016 The target address SHALL be SR.addr when inc=0, and last_addr+STEP (modulo 2^ADDR_W, wraps to 0) when inc=1.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
- IDLE to REQ: on a valid update.
- REQ: mem_req_o=1 for exactly one cycle, then WAIT.
- WAIT: hold address/data/we until mem_ack_i=1, then DONE.
- DONE: one cycle, then IDLE.
REQ-018 mem_req_o SHALL assert 1 cycle after update_dr_i; an ack in the same cycle as the request SHALL be ignored.
REQ-019 On ack of a READ, last_rdata SHALL take mem_rdata_i. last_addr SHALL take the target address on every acked access.
REQ-020 busy_o SHALL be 1 in REQ, WAIT and DONE, and 0 in IDLE.
REQ-021 An update_dr_i while busy_o=1 SHALL be dropped and set err (sticky). SR shifting while busy SHALL be unaffected.
REQ-022 err SHALL clear on a capture_dr_i whose captured err bit is 1, i.e. clear-on-read.
REQ-023 Strobes with sel_i=0 SHALL be ignored entirely; tdo_o holds its value.
REQ-024 If mem_ack_i has not arrived 255 cycles after the request, the loader SHALL go to IDLE, set err and leave last_addr unchanged.

Reset
REQ-025 rstn_i low SHALL asynchronously force all of the following to 0, regardless of the operation in progress:
- SR, last_addr, last_rdata, err, tdo_o
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
- FSM to IDLE
REQ-026 A reset during WAIT SHALL abandon the access; a late mem_ack_i after release SHALL be ignored.

Configuration
REQ-027 Macro IMEM_SCAN_READBACK_EN SHALL compile the READ path in: rd decode, the last_rdata register and the mem_rdata_i capture.
REQ-028 Without IMEM_SCAN_READBACK_EN:
- rd=1 and we=0 SHALL be a NOP that sets err.
- The captured data field SHALL be all zeros.
- mem_rdata_i SHALL be unused.

Verification
REQ-029 Write test: ADDR_W=10, DATA_W=32; shift {10'h004, 32'h0130_0093, 0,0,1} and update -> one mem_req_o, mem_addr_o=0x004, mem_wdata_o=0x01300093, mem_we_o=1; after ack, capture shows addr 0x004.
REQ-030 Auto-increment test: write at 0x3FC, then inc=1 writes twice -> addresses 0x000 then 0x004 (wrap).
REQ-031 Busy-drop test: hold mem_ack_i low and issue a second update -> no second mem_req_o; capture shows err=1; the next capture shows err=0.
REQ-032 Readback test (IMEM_SCAN_READBACK_EN defined): rd=1 at 0x010 with mem_rdata_i=0xDEADBEEF -> the next capture shifts out data 0xDEADBEEF over tdo_o, LSB first after the status bits.
REQ-033 Reset-in-WAIT test: pull rstn_i low in WAIT, then ack after release -> all outputs 0 and no state change.
REQ-034 Timeout test: no ack for 255 cycles -> busy_o falls and err=1.
